// File: rtl/logic_pkg.sv
// Shared widths, opcode encoding and buffered-entry layout for the logic result stage.
package logic_pkg;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned TAG_W = 6;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } logic_op_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             neg;
  } logic_entry_t;

endpackage

// File: rtl/logic_skid_fifo.sv
// Two-entry in-order buffer; slot 0 is always the head, slot 1 the entry behind it.
module logic_skid_fifo
  import logic_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic_entry_t push_data,
  output logic_entry_t head_data,
  output logic         full,
  output logic         empty
);

  logic [1:0]   count_q, count_d;
  logic_entry_t slot0_q, slot0_d;
  logic_entry_t slot1_q, slot1_d;
  logic         push_ok, pop_ok;

  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign head_data = slot0_q;
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (empty) slot0_d = push_data;
          else       slot1_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new entry lands directly behind whatever survives the pop.
          if (count_q == 2'd1) begin
            slot0_d = push_data;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

endmodule

// File: rtl/logic_result_stage.sv
// Selects the requested gate-array result, precomputes its flags and queues it for writeback.
module logic_result_stage
  import logic_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_and,
  input  logic [WIDTH-1:0] in_or,
  input  logic [WIDTH-1:0] in_xor,
  input  logic [WIDTH-1:0] in_nor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg
);

  logic [WIDTH-1:0] sel_result;
  logic_entry_t     new_entry;
  logic_entry_t     head_entry;
  logic             full, empty, push, pop;

  always_comb begin
    sel_result = '0;
    case (logic_op_e'(in_op))
      OP_AND:  sel_result = in_and;
      OP_OR:   sel_result = in_or;
      OP_XOR:  sel_result = in_xor;
      OP_NOR:  sel_result = in_nor;
      default: sel_result = '0;
    endcase
  end

  always_comb begin
    new_entry        = '0;
    new_entry.result = sel_result;
    new_entry.tag    = in_tag;
    new_entry.zero   = (sel_result == '0);
    new_entry.neg    = sel_result[WIDTH-1];
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  logic_skid_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (new_entry),
    .head_data (head_entry),
    .full      (full),
    .empty     (empty)
  );

  // Stored slots keep stale data after a pop; gate so an empty stage reads all zeros.
  assign out_result = empty ? '0 : head_entry.result;
  assign out_tag    = empty ? '0 : head_entry.tag;
  assign out_zero   = !empty && head_entry.zero;
  assign out_neg    = !empty && head_entry.neg;

endmodule

// File: tb/tb_logic_result_stage.sv
// Directed bench for logic_result_stage: reset, single op, backpressure, streaming, flush, reset mid-stream.
module tb_logic_result_stage;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_zero, out_neg;
  logic [1:0]  in_op;
  logic [63:0] in_and, in_or, in_xor, in_nor, out_result;
  logic [5:0]  in_tag, out_tag;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  logic_result_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_and     (in_and),
    .in_or      (in_or),
    .in_xor     (in_xor),
    .in_nor     (in_nor),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_zero   (out_zero),
    .out_neg    (out_neg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chk_empty(input string name);
    chk({name, ".valid"},  {63'd0, out_valid}, 64'd0);
    chk({name, ".ready"},  {63'd0, in_ready},  64'd1);
    chk({name, ".result"}, out_result,         64'd0);
    chk({name, ".tag"},    {58'd0, out_tag},   64'd0);
    chk({name, ".zero"},   {63'd0, out_zero},  64'd0);
    chk({name, ".neg"},    {63'd0, out_neg},   64'd0);
  endtask

  task automatic set_in(input logic [1:0] op, input logic [5:0] tag,
                        input logic [63:0] a, input logic [63:0] o,
                        input logic [63:0] x, input logic [63:0] n);
    in_valid = 1'b1;
    in_op    = op;
    in_tag   = tag;
    in_and   = a;
    in_or    = o;
    in_xor   = x;
    in_nor   = n;
  endtask

  initial begin
    logic [63:0] a, o, x, n, exp_r;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_tag = '0;
    in_and = '0; in_or = '0; in_xor = '0; in_nor = '0;

    // Reset then idle
    tick(); tick();
    reset_n = 1'b1;
    chk_empty("reset");
    tick();
    chk_empty("idle");

    // Single NOR op with zero result
    out_ready = 1'b1;
    set_in(2'b11, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'h8000_0000_0000_0000, 64'h0);
    tick();
    in_valid = 1'b0;
    chk("nor.valid",  {63'd0, out_valid}, 64'd1);
    chk("nor.result", out_result,         64'd0);
    chk("nor.zero",   {63'd0, out_zero},  64'd1);
    chk("nor.neg",    {63'd0, out_neg},   64'd0);
    chk("nor.tag",    {58'd0, out_tag},   64'd5);
    tick();
    chk_empty("nor.drain");

    // Backpressure
    out_ready = 1'b0;
    set_in(2'b10, 6'd1, 64'h0F, 64'hF0, 64'h8000_0000_0000_0001, 64'h55);
    tick();
    chk("bp.ready1", {63'd0, in_ready},  64'd1);
    chk("bp.tag1",   {58'd0, out_tag},   64'd1);
    set_in(2'b00, 6'd2, 64'h0000_0000_0000_00F0, 64'h1, 64'h2, 64'h3);
    tick();
    in_valid = 1'b0;
    chk("bp.ready_full", {63'd0, in_ready},  64'd0);
    chk("bp.head_tag",   {58'd0, out_tag},   64'd1);
    chk("bp.head_neg",   {63'd0, out_neg},   64'd1);
    chk("bp.head_res",   out_result,         64'h8000_0000_0000_0001);
    tick();
    chk("bp.hold_tag",   {58'd0, out_tag},   64'd1);
    chk("bp.hold_res",   out_result,         64'h8000_0000_0000_0001);
    chk("bp.hold_zero",  {63'd0, out_zero},  64'd0);
    chk("bp.hold_ready", {63'd0, in_ready},  64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp.tag2",    {58'd0, out_tag},   64'd2);
    chk("bp.res2",    out_result,         64'h0000_0000_0000_00F0);
    chk("bp.neg2",    {63'd0, out_neg},   64'd0);
    chk("bp.ready2",  {63'd0, in_ready},  64'd1);
    chk("bp.valid2",  {63'd0, out_valid}, 64'd1);
    tick();
    chk_empty("bp.drain");

    // Streaming: one result per cycle, in order
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = 64'h0123_4567_89AB_CDEF ^ (64'(i) << 8);
      o = ~a;
      x = {4'(i), 60'h5};
      n = a << i;
      case (i % 4)
        0:       exp_r = a;
        1:       exp_r = o;
        2:       exp_r = x;
        default: exp_r = n;
      endcase
      set_in(2'(i % 4), 6'(i), a, o, x, n);
      tick();
      chk($sformatf("st%0d.valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("st%0d.tag", i),   {58'd0, out_tag},   64'(i));
      chk($sformatf("st%0d.res", i),   out_result,         exp_r);
      chk($sformatf("st%0d.zero", i),  {63'd0, out_zero},  {63'd0, exp_r == 64'd0});
      chk($sformatf("st%0d.neg", i),   {63'd0, out_neg},   {63'd0, exp_r[63]});
      chk($sformatf("st%0d.ready", i), {63'd0, in_ready},  64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk_empty("st.drain");

    // Flush with full buffer plus simultaneous push of tag 9
    out_ready = 1'b0;
    set_in(2'b01, 6'd7, 64'h0, 64'h77, 64'h0, 64'h0);
    tick();
    set_in(2'b01, 6'd8, 64'h0, 64'h88, 64'h0, 64'h0);
    tick();
    chk("fl.full", {63'd0, in_ready}, 64'd0);
    flush = 1'b1; out_ready = 1'b1;
    set_in(2'b01, 6'd9, 64'h0, 64'h99, 64'h0, 64'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_empty("fl.full_after");
    tick();
    chk("fl.no9a", {63'd0, out_valid}, 64'd0);

    // Flush at count 1 with an otherwise-accepted push of tag 9
    out_ready = 1'b0;
    set_in(2'b01, 6'd10, 64'h0, 64'hAA, 64'h0, 64'h0);
    tick();
    chk("fl1.tag10", {58'd0, out_tag}, 64'd10);
    flush = 1'b1;
    set_in(2'b01, 6'd9, 64'h0, 64'h99, 64'h0, 64'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk_empty("fl1.after");
    tick();
    chk("fl1.no9", {63'd0, out_valid}, 64'd0);

    // Reset mid-stream with a full buffer
    out_ready = 1'b0;
    set_in(2'b10, 6'd3, 64'h0, 64'h0, 64'h8000_0000_0000_0003, 64'h0);
    tick();
    set_in(2'b10, 6'd4, 64'h0, 64'h0, 64'h4, 64'h0);
    tick();
    in_valid = 1'b0;
    chk("rs.full", {63'd0, in_ready}, 64'd0);
    reset_n = 1'b0; out_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    chk_empty("rs.after");
    tick();
    chk("rs.no_old1", {63'd0, out_valid}, 64'd0);
    tick();
    chk("rs.no_old2", {63'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
